// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage elastic valid/ready pipeline with bubble collapse, stall, per-stage flush and occupancy count.
// Define PIPE_REG_ZERO_DATA_EN to zero payloads on flush/bubble so idle out_data_o reads 0.
module pipe_reg_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    input  logic             stall_i,
    input  logic [DEPTH-1:0] flush_i,
    output logic [CNT_W-1:0] count_o
);
    logic [DEPTH-1:0] v_q, v_d, rdy, ld, src_v;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic r;
    // a stage may load when it or any stage ahead of it has room
    always_comb begin
        r = out_ready_i;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r = r | ~v_q[k];
            rdy[k] = r;
        end
    end
    assign ld = rdy & {DEPTH{~stall_i}};
    always_comb begin
        src_v[0] = in_valid_i;
        src_d[0] = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end
    always_comb begin
        v_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = ~flush_i[k] & (ld[k] ? src_v[k] : v_q[k]);
`ifdef PIPE_REG_ZERO_DATA_EN
            d_d[k] = (flush_i[k] | (ld[k] & ~src_v[k])) ? '0 : ld[k] ? src_d[k] : d_q[k];
`else
            d_d[k] = (ld[k] & src_v[k]) ? src_d[k] : d_q[k];
`endif
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
        end
    end
    always_comb begin
        count_o = '0;
        for (int k = 0; k < DEPTH; k++) count_o = count_o + CNT_W'(v_q[k]);
    end
    assign in_ready_o  = rdy[0] & ~stall_i & ~rst_i;
    assign out_valid_o = v_q[DEPTH-1] & ~stall_i;
`ifdef PIPE_REG_ZERO_DATA_EN
    assign out_data_o  = out_valid_o ? d_q[DEPTH-1] : '0;
`else
    assign out_data_o  = d_q[DEPTH-1];
`endif
endmodule
